// File: rtl/ddmtd_meas_ctrl_if.sv
// Host-side control/result bundle for the DDMTD measurement sequencer.
// The master drives start/abort/configuration and the result ready strobe;
// the slave (the sequencer) returns busy, the result handshake and timeout.
interface ddmtd_meas_ctrl_if #(
    parameter int COUNTER_BIT_WIDTH = 16,
    parameter int TIMEOUT_BIT_WIDTH = 24
);
    logic                                start_i;
    logic                                abort_i;
    logic [15:0]                         threshold_cfg_i;
    logic [TIMEOUT_BIT_WIDTH-1:0]        timeout_cfg_i;
    logic                                busy_o;
    logic signed [COUNTER_BIT_WIDTH-1:0] result_o;
    logic [COUNTER_BIT_WIDTH-1:0]        result_pkpk_o;
    logic                                result_valid_o;
    logic                                result_ready_i;
    logic                                timeout_o;

    modport master (
        output start_i, abort_i, threshold_cfg_i, timeout_cfg_i, result_ready_i,
        input  busy_o, result_o, result_pkpk_o, result_valid_o, timeout_o
    );

    modport slave (
        input  start_i, abort_i, threshold_cfg_i, timeout_cfg_i, result_ready_i,
        output busy_o, result_o, result_pkpk_o, result_valid_o, timeout_o
    );
endinterface

// File: rtl/ddmtd_meas_ctrl.sv
// DDMTD measurement sequencer (clk_ddmtd_i domain).
// Flushes the DDMTD core, drops the first partial tag pairing, then averages
// 2^AVG_LOG2 phase samples relative to the first one so that phase wrap at
// +/-2^(N-1) does not corrupt the mean. Result leaves via valid/ready.
// Optional feature macro: DDMTD_MEAS_MINMAX_EN builds the min/max tracking
// behind result_pkpk_o; without it result_pkpk_o is tied to 0.
module ddmtd_meas_ctrl #(
    parameter int          COUNTER_BIT_WIDTH = 16,
    parameter int          AVG_LOG2          = 4,
    parameter int          TIMEOUT_BIT_WIDTH = 24,
    parameter logic [15:0] RESET_THRESHOLD   = 16'd100
) (
    input  logic                                clk_ddmtd_i,
    input  logic                                rst_n_ddmtdclk_i,
    input  logic signed [COUNTER_BIT_WIDTH-1:0] phase_diff_i,
    input  logic                                phase_diff_p_i,
    output logic [15:0]                         deglitch_threshold_o,
    output logic                                ddmtd_rst_n_o,
    ddmtd_meas_ctrl_if.slave                    host
);
    localparam int N  = COUNTER_BIT_WIDTH;
    localparam int SW = N + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int TW = TIMEOUT_BIT_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        DISCARD = 3'd2,
        ACCUM   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]          flush_cnt_reg;
    logic [TW-1:0]       tmo_cnt_reg, tmo_cnt_next;
    logic [CW-1:0]       smp_cnt_reg;
    logic signed [N-1:0] ref_reg;
    logic signed [SW-1:0] acc_reg;
    logic signed [N-1:0] result_reg;
    logic [15:0]         thr_reg;
    logic                busy_reg, valid_reg, ddmtd_rst_n_reg, timeout_reg;

    logic                start_acc, sample_acc, tmo_fire, tmo_hit, last_sample, in_wait;
    logic signed [N-1:0] ref_sel, delta, result_calc;
    logic signed [SW-1:0] acc_sum;

    // Sample arithmetic: delta against the reference (the sample itself for
    // the first one, giving 0), widened accumulator sum and floored mean.
    always_comb begin
        ref_sel     = (smp_cnt_reg == '0) ? phase_diff_i : ref_reg;
        delta       = phase_diff_i - ref_sel;
        acc_sum     = acc_reg + $signed({{AVG_LOG2{delta[N-1]}}, delta});
        result_calc = ref_sel + N'(acc_sum >>> AVG_LOG2);
    end

    // State register.
    always_ff @(posedge clk_ddmtd_i or negedge rst_n_ddmtdclk_i) begin
        if (!rst_n_ddmtdclk_i) state_reg <= IDLE;
        else                   state_reg <= state_next;
    end

    // Next-state logic and datapath strobes; abort overrides everything.
    always_comb begin
        state_next  = state_reg;
        start_acc   = 1'b0;
        sample_acc  = 1'b0;
        tmo_fire    = 1'b0;
        last_sample = (smp_cnt_reg == LAST_IDX);
        in_wait     = (state_reg == DISCARD) || (state_reg == ACCUM);
        // A pulse on the terminal count is a sample, not a timeout.
        tmo_hit     = (host.timeout_cfg_i != '0) && (tmo_cnt_reg == host.timeout_cfg_i)
                      && !phase_diff_p_i;
        if (host.abort_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (host.start_i) begin
                        state_next = FLUSH;
                        start_acc  = 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == 2'd3) state_next = DISCARD;
                end
                DISCARD: begin
                    if (phase_diff_p_i) begin
                        state_next = ACCUM;
                    end else if (tmo_hit) begin
                        state_next = IDLE;
                        tmo_fire   = 1'b1;
                    end
                end
                ACCUM: begin
                    if (phase_diff_p_i) begin
                        sample_acc = 1'b1;
                        if (last_sample) state_next = DONE;
                    end else if (tmo_hit) begin
                        state_next = IDLE;
                        tmo_fire   = 1'b1;
                    end
                end
                DONE: begin
                    if (valid_reg && host.result_ready_i) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
        // Inter-pulse timer restarts on every pulse and on any state change.
        if (!in_wait || (state_next != state_reg) || phase_diff_p_i) tmo_cnt_next = '0;
        else                                                         tmo_cnt_next = tmo_cnt_reg + TW'(1);
    end

    // Flush length counter, timeout counter and mean accumulator.
    always_ff @(posedge clk_ddmtd_i or negedge rst_n_ddmtdclk_i) begin
        if (!rst_n_ddmtdclk_i) begin
            flush_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            smp_cnt_reg   <= '0;
            ref_reg       <= '0;
            acc_reg       <= '0;
            result_reg    <= '0;
        end else begin
            flush_cnt_reg <= (state_reg == FLUSH) ? flush_cnt_reg + 2'd1 : 2'd0;
            tmo_cnt_reg   <= tmo_cnt_next;
            if (start_acc) begin
                smp_cnt_reg <= '0;
                acc_reg     <= '0;
            end else if (sample_acc) begin
                smp_cnt_reg <= smp_cnt_reg + CW'(1);
                ref_reg     <= ref_sel;
                acc_reg     <= acc_sum;
                if (last_sample) result_reg <= result_calc;
            end
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk_ddmtd_i or negedge rst_n_ddmtdclk_i) begin
        if (!rst_n_ddmtdclk_i) begin
            busy_reg        <= 1'b0;
            valid_reg       <= 1'b0;
            ddmtd_rst_n_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            thr_reg         <= RESET_THRESHOLD;
        end else begin
            busy_reg        <= (state_next == FLUSH) || (state_next == DISCARD)
                               || (state_next == ACCUM);
            valid_reg       <= (state_next == DONE);
            ddmtd_rst_n_reg <= (state_next != FLUSH);
            if (start_acc)     timeout_reg <= 1'b0;
            else if (tmo_fire) timeout_reg <= 1'b1;
            if (start_acc)     thr_reg <= host.threshold_cfg_i;
        end
    end

`ifdef DDMTD_MEAS_MINMAX_EN
    logic signed [N-1:0] min_reg, max_reg, min_new, max_new;
    logic [N-1:0]        pkpk_reg;

    // Running extremes of the deltas including the current sample.
    always_comb begin
        min_new = (delta < min_reg) ? delta : min_reg;
        max_new = (delta > max_reg) ? delta : max_reg;
    end

    // Min/max tracking; both start at 0, the first sample's delta.
    always_ff @(posedge clk_ddmtd_i or negedge rst_n_ddmtdclk_i) begin
        if (!rst_n_ddmtdclk_i) begin
            min_reg  <= '0;
            max_reg  <= '0;
            pkpk_reg <= '0;
        end else if (start_acc) begin
            min_reg <= '0;
            max_reg <= '0;
        end else if (sample_acc) begin
            min_reg <= min_new;
            max_reg <= max_new;
            if (last_sample) pkpk_reg <= max_new - min_new;
        end
    end

    assign host.result_pkpk_o = pkpk_reg;
`else
    assign host.result_pkpk_o = '0;
`endif

    assign deglitch_threshold_o = thr_reg;
    assign ddmtd_rst_n_o        = ddmtd_rst_n_reg;
    assign host.busy_o          = busy_reg;
    assign host.result_o        = result_reg;
    assign host.result_valid_o  = valid_reg;
    assign host.timeout_o       = timeout_reg;
endmodule

// File: doc/ddmtd_meas_ctrl.md
# ddmtd_meas_ctrl

Measurement sequencer for the DDMTD phase detector, in the `clk_ddmtd_i` domain.
- Configures the deglitch threshold and resets the DDMTD core to flush stale tag pairings.
- Accumulates 2^AVG_LOG2 `phase_diff` samples wrap-safely and presents the mean, plus optional peak-to-peak spread, through a valid/ready handshake.
- Guards against missing tags with a programmable timeout.

## Interface
- `COUNTER_BIT_WIDTH`, 16: width of DDMTD phase samples (N).
- `AVG_LOG2`, 4: log2 of samples averaged per measurement (1..8).
- `TIMEOUT_BIT_WIDTH`, 24: width of timeout counter.
- `RESET_THRESHOLD`, 16'd100: `deglitch_threshold_o` value out of reset.
- `clk_ddmtd_i`  in  1  DDMTD sampling clock; the only clock.
- `rst_n_ddmtdclk_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start a measurement; honoured only in IDLE.
- `abort_i`  in  1  abandon the current measurement; any state.
- `threshold_cfg_i`  in  16  deglitch threshold, latched on accepted start.
- `timeout_cfg_i`  in  TIMEOUT_BIT_WIDTH  maximum cycles between pulses; 0 disables the timeout.
- `phase_diff_i`  in  N signed  sample from the DDMTD core.
- `phase_diff_p_i`  in  1  1-cycle valid pulse for `phase_diff_i`.
- `deglitch_threshold_o`  out  16  threshold driven to the DDMTD core.
- `ddmtd_rst_n_o`  out  1  synchronous active-low reset to the DDMTD core.
- `busy_o`  out  1  high in FLUSH, DISCARD and ACCUM.
- `result_o`  out  N signed  mean phase difference (mod 2^N).
- `result_pkpk_o`  out  N unsigned  max minus min unwrapped sample.
- `result_valid_o`  out  1  result available.
- `result_ready_i`  in  1  consumer accepts the result.
- `timeout_o`  out  1  sticky; last measurement timed out.

## Operation
- States: IDLE, FLUSH, DISCARD, ACCUM, DONE.
- IDLE, on `start_i` (and not `abort_i`):
  - Latch `threshold_cfg_i` into `deglitch_threshold_o`.
  - Clear `timeout_o`, accumulator, sample count and min/max.
  - Go to FLUSH.
- FLUSH: `ddmtd_rst_n_o`=0 for exactly 4 cycles, then DISCARD. Pulses are ignored.
- DISCARD: drop the first `phase_diff_p_i` (a partial pairing after reset), then go to ACCUM.
- ACCUM:
  - The first accepted sample becomes reference R; its delta is 0.
  - Each later sample gives d = (sample − R) mod 2^N, interpreted as signed N-bit.
  - Sum d into a signed accumulator S of width N+AVG_LOG2; this width cannot overflow.
  - Track min(d) and max(d).
  - After the 2^AVG_LOG2-th sample:
    - `result_o` = (R + (S >>> AVG_LOG2)) mod 2^N. The shift is arithmetic, so the mean is floored.
    - `result_pkpk_o` = max(d) − min(d), which fits N bits unsigned.
    - Go to DONE.
- DONE:
  - `result_valid_o`=1. Result outputs stay stable and pulses are ignored.
  - When `result_valid_o` and `result_ready_i` are both high, return to IDLE.
  - `start_i` is ignored until the handshake completes.
- Timeout (DISCARD/ACCUM):
  - The counter increments each cycle and is cleared on each `phase_diff_p_i` and on state entry.
  - If it reaches a nonzero `timeout_cfg_i`: set `timeout_o`, go to IDLE, no result.
- `abort_i`:
  - From any state: go to IDLE next cycle and drop `result_valid_o`.
  - `ddmtd_rst_n_o` returns to 1.
  - `timeout_o` is unchanged.
  - `abort_i` wins over simultaneous `start_i`, pulses or handshake.
- A pulse coinciding with a timeout terminal count counts as a sample; no timeout fires.

## Timing
- All outputs are registered.
- Reset values:
  - `busy_o`=0, `result_valid_o`=0, `result_o`=0, `result_pkpk_o`=0, `timeout_o`=0.
  - `ddmtd_rst_n_o`=0, which holds the core in reset while the controller is in reset; it is 1 from the first cycle in IDLE.
  - `deglitch_threshold_o`=`RESET_THRESHOLD`.
  - State IDLE.
- Start sampled at cycle 0: `busy_o` and `ddmtd_rst_n_o`=0 in cycles 1–4. DISCARD begins at cycle 5 with `ddmtd_rst_n_o`=1.
- Final sample pulse at cycle k: `result_valid_o`=1 and the result is valid at k+1; `busy_o`=0 at k+1.
- Handshake at cycle h: `result_valid_o`=0 at h+1. A start at h+1 is accepted.
- Timeout is detected at cycle t: `timeout_o`=1 and `busy_o`=0 at t+1.
- Asynchronous reset mid-operation forces all reset values immediately.

## Configuration
- `DDMTD_MEAS_MINMAX_EN` defined: min/max tracking is built and `result_pkpk_o` is computed as above.
- Not defined: min/max logic is omitted and `result_pkpk_o` is constant 0. Mean, handshake and timeout behaviour are identical.

## Test plan
- Constant: N=16, AVG_LOG2=4; start, then 17 pulses of +100 → `result_o`=100, `result_pkpk_o`=0, `result_valid_o` 1 cycle after the 17th pulse.
- Wrap: after the discard pulse, 16 samples alternating 32767 and −32768 → `result_o`=32767 (not ≈0), `result_pkpk_o`=1.
- Flush/threshold: `threshold_cfg_i`=500, start at cycle 0 → `ddmtd_rst_n_o` low exactly in cycles 1–4; `deglitch_threshold_o`=500 from cycle 1; pulses in cycles 1–4 are not counted.
- Timeout: `timeout_cfg_i`=1000, no pulses after start → `timeout_o`=1 and `busy_o`=0 at 1001 cycles after DISCARD entry; `result_valid_o` stays 0; next start clears `timeout_o`.
- Backpressure: `result_ready_i`=0 for 50 cycles with pulses and `start_i` applied → result and valid held unchanged; after ready, IDLE next cycle.
- Abort/reset: `abort_i` after 5 ACCUM samples → IDLE next cycle; a new measurement of constant −20 gives `result_o`=−20. Async reset mid-ACCUM → reset values immediately.
